// File: rtl/data_memory_loader.sv
// Streams a fixed-length byte load into the data RAM while the processor is held in reset,
// then releases the processor and hands it the RAM write port.
module data_memory_loader #(
  parameter int unsigned ADDR_W    = 19,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned LOAD_LEN  = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       cpu_m_address,
  input  logic [31:0]       cpu_m_data,
  input  logic              cpu_memw,
  output logic [ADDR_W-1:0] ram_address,
  output logic [7:0]        ram_data,
  output logic              ram_wren,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StRun} state_e;

  localparam logic [ADDR_W-1:0] BaseAddr  = ADDR_W'(BASE_ADDR);
  // count carries one extra bit so a full 2^ADDR_W load is representable
  localparam logic [ADDR_W:0]   LastCount = (ADDR_W + 1)'(LOAD_LEN - 1);
  localparam logic [ADDR_W:0]   CountOne  = (ADDR_W + 1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [7:0]        pend_data_q, pend_data_d;
  logic              accept;

  logic unused_cpu_bits;
  assign unused_cpu_bits = ^{cpu_m_address[31:ADDR_W], cpu_m_data[31:8]};

  assign accept = (state_q == StLoad) && s_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      count_q      <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    pend_valid_d = 1'b0;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          count_d = '0;
        end
      end
      StLoad: begin
        if (accept) begin
          pend_valid_d = 1'b1;
          pend_addr_d  = BaseAddr + count_q[ADDR_W-1:0];
          pend_data_d  = s_data;
          count_d      = count_q + CountOne;
          if (count_q == LastCount) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        state_d = StRun;
      end
      StRun: begin
        if (start) begin
          state_d = StLoad;
          count_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    s_ready     = (state_q == StLoad);
    busy        = (state_q == StLoad) || (state_q == StFlush);
    done        = (state_q == StRun);
    cpu_rst     = (state_q != StRun);
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    // Processor owns the port only in RUN; otherwise only a loader write is visible
    if (state_q == StRun) begin
      ram_address = cpu_m_address[ADDR_W-1:0];
      ram_data    = cpu_m_data[7:0];
      ram_wren    = cpu_memw;
    end else if (pend_valid_q) begin
      ram_address = pend_addr_q;
      ram_data    = pend_data_q;
      ram_wren    = 1'b1;
    end
  end

endmodule

// File: tb/tb_data_memory_loader.sv
// Directed bench: a cycle table for the main loader plus hand sequences for wrap-around,
// single-byte and full-address-space loads.
module tb_data_memory_loader;

  logic clk;
  logic rst;
  logic [7:0] s_data;
  logic [31:0] cpu_m_address, cpu_m_data;
  logic cpu_memw;

  logic start, s_valid, s_ready, ram_wren, cpu_rst, busy, done;
  logic [18:0] ram_address;
  logic [7:0] ram_data;

  logic w_start, w_valid, w_ready, w_wren, w_cpu_rst, w_busy, w_done;
  logic [18:0] w_address;
  logic [7:0] w_data;

  logic o_start, o_valid, o_ready, o_wren, o_cpu_rst, o_busy, o_done;
  logic [18:0] o_address;
  logic [7:0] o_data;

  logic f_start, f_valid, f_ready, f_wren, f_cpu_rst, f_busy, f_done;
  logic [2:0] f_address;
  logic [7:0] f_data;

  int checks = 0;
  int errors = 0;

  data_memory_loader #(.ADDR_W(19), .BASE_ADDR(32'h100), .LOAD_LEN(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .cpu_m_address(cpu_m_address), .cpu_m_data(cpu_m_data),
    .cpu_memw(cpu_memw), .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .cpu_rst(cpu_rst), .busy(busy), .done(done)
  );

  data_memory_loader #(.ADDR_W(19), .BASE_ADDR(32'h7FFFE), .LOAD_LEN(4)) u_wrap (
    .clk(clk), .rst(rst), .start(w_start), .s_data(s_data), .s_valid(w_valid),
    .s_ready(w_ready), .cpu_m_address(cpu_m_address), .cpu_m_data(cpu_m_data),
    .cpu_memw(cpu_memw), .ram_address(w_address), .ram_data(w_data),
    .ram_wren(w_wren), .cpu_rst(w_cpu_rst), .busy(w_busy), .done(w_done)
  );

  data_memory_loader #(.ADDR_W(19), .BASE_ADDR(32'h5), .LOAD_LEN(1)) u_one (
    .clk(clk), .rst(rst), .start(o_start), .s_data(s_data), .s_valid(o_valid),
    .s_ready(o_ready), .cpu_m_address(cpu_m_address), .cpu_m_data(cpu_m_data),
    .cpu_memw(cpu_memw), .ram_address(o_address), .ram_data(o_data),
    .ram_wren(o_wren), .cpu_rst(o_cpu_rst), .busy(o_busy), .done(o_done)
  );

  data_memory_loader #(.ADDR_W(3), .BASE_ADDR(6), .LOAD_LEN(8)) u_full (
    .clk(clk), .rst(rst), .start(f_start), .s_data(s_data), .s_valid(f_valid),
    .s_ready(f_ready), .cpu_m_address(cpu_m_address), .cpu_m_data(cpu_m_data),
    .cpu_memw(cpu_memw), .ram_address(f_address), .ram_data(f_data),
    .ram_wren(f_wren), .cpu_rst(f_cpu_rst), .busy(f_busy), .done(f_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, start, sv;
    logic [7:0]  sd;
    logic [31:0] ca, cd;
    logic        cw;
    logic        srdy, wren;
    logic [18:0] addr;
    logic [7:0]  data;
    logic        crst, busy, done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input int unsigned rst_v, start_v, sv, sd, ca, cd, cw,
                             srdy, wren, addr, data, crst, busy_v, done_v);
    vec_t r;
    r.rst = rst_v[0];   r.start = start_v[0]; r.sv = sv[0];       r.sd = sd[7:0];
    r.ca = ca;          r.cd = cd;            r.cw = cw[0];
    r.srdy = srdy[0];   r.wren = wren[0];     r.addr = addr[18:0]; r.data = data[7:0];
    r.crst = crst[0];   r.busy = busy_v[0];   r.done = done_v[0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  logic [7:0]  wb[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [18:0] wa[4] = '{19'h7FFFE, 19'h7FFFF, 19'h00000, 19'h00001};
  logic [2:0]  fa[8] = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

  initial begin
    rst = 1'b1; start = 0; s_valid = 0; s_data = 0;
    cpu_m_address = 0; cpu_m_data = 0; cpu_memw = 0;
    w_start = 0; w_valid = 0; o_start = 0; o_valid = 0; f_start = 0; f_valid = 0;

    // rst start sv sd | ca cd cw | srdy wren addr data | crst busy done
    vecs.push_back(v(1,0,0,'h00, 0,0,0, 0,0,0,0, 1,0,0));
    vecs.push_back(v(0,0,1,'hEE, 0,0,0, 0,0,0,0, 1,0,0));
    vecs.push_back(v(0,1,1,'hEE, 0,0,0, 0,0,0,0, 1,0,0));
    vecs.push_back(v(0,0,1,'hA1, 0,0,0, 1,0,0,0, 1,1,0));
    vecs.push_back(v(0,0,1,'hB2, 0,0,0, 1,1,'h100,'hA1, 1,1,0));
    vecs.push_back(v(0,0,1,'hC3, 0,0,0, 1,1,'h101,'hB2, 1,1,0));
    vecs.push_back(v(0,0,1,'hD4, 0,0,0, 1,1,'h102,'hC3, 1,1,0));
    vecs.push_back(v(0,0,1,'h77, 0,0,0, 0,1,'h103,'hD4, 1,1,0));
    vecs.push_back(v(0,0,0,'h00, 'hABCDE,'h5A,1, 0,1,'h2BCDE,'h5A, 0,0,1));
    vecs.push_back(v(0,0,0,'h00, 'h12345,'h1FF,0, 0,0,'h12345,'hFF, 0,0,1));
    vecs.push_back(v(0,1,0,'h00, 'h12345,'h1FF,0, 0,0,'h12345,'hFF, 0,0,1));
    vecs.push_back(v(0,0,1,'hA1, 'h12345,'h1FF,1, 1,0,0,0, 1,1,0));
    vecs.push_back(v(0,0,0,'h00, 0,0,0, 1,1,'h100,'hA1, 1,1,0));
    vecs.push_back(v(0,0,0,'h00, 0,0,0, 1,0,0,0, 1,1,0));
    vecs.push_back(v(0,0,1,'hB2, 0,0,0, 1,0,0,0, 1,1,0));
    vecs.push_back(v(0,0,1,'hC3, 0,0,0, 1,1,'h101,'hB2, 1,1,0));
    vecs.push_back(v(0,0,0,'h00, 0,0,0, 1,1,'h102,'hC3, 1,1,0));
    vecs.push_back(v(0,0,1,'hD4, 0,0,0, 1,0,0,0, 1,1,0));
    vecs.push_back(v(0,0,0,'h00, 0,0,0, 0,1,'h103,'hD4, 1,1,0));
    vecs.push_back(v(0,0,0,'h00, 0,0,0, 0,0,0,0, 0,0,1));
    vecs.push_back(v(0,1,0,'h00, 0,0,0, 0,0,0,0, 0,0,1));
    vecs.push_back(v(0,0,1,'hA1, 0,0,0, 1,0,0,0, 1,1,0));
    vecs.push_back(v(0,0,1,'hB2, 0,0,0, 1,1,'h100,'hA1, 1,1,0));
    vecs.push_back(v(0,1,1,'hC3, 0,0,0, 1,1,'h101,'hB2, 1,1,0));
    vecs.push_back(v(0,0,1,'hD4, 0,0,0, 1,1,'h102,'hC3, 1,1,0));
    vecs.push_back(v(0,0,0,'h00, 0,0,0, 0,1,'h103,'hD4, 1,1,0));
    vecs.push_back(v(0,1,0,'h00, 0,0,0, 0,0,0,0, 0,0,1));
    vecs.push_back(v(0,0,1,'hA1, 0,0,0, 1,0,0,0, 1,1,0));
    vecs.push_back(v(0,0,1,'hB2, 0,0,0, 1,1,'h100,'hA1, 1,1,0));
    vecs.push_back(v(1,0,1,'hC3, 0,0,0, 1,1,'h101,'hB2, 1,1,0));
    vecs.push_back(v(0,0,1,'hC3, 0,0,0, 0,0,0,0, 1,0,0));
    vecs.push_back(v(1,1,0,'h00, 0,0,0, 0,0,0,0, 1,0,0));
    vecs.push_back(v(0,1,1,'hEE, 0,0,0, 0,0,0,0, 1,0,0));
    vecs.push_back(v(0,0,1,'hA1, 0,0,0, 1,0,0,0, 1,1,0));
    vecs.push_back(v(0,0,0,'h00, 0,0,0, 1,1,'h100,'hA1, 1,1,0));
    vecs.push_back(v(0,0,0,'h00, 0,0,0, 1,0,0,0, 1,1,0));

    @(posedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; start = vecs[i].start; s_valid = vecs[i].sv; s_data = vecs[i].sd;
      cpu_m_address = vecs[i].ca; cpu_m_data = vecs[i].cd; cpu_memw = vecs[i].cw;
      #1;
      chk($sformatf("vec%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].srdy));
      chk($sformatf("vec%0d_ram_wren", i), 32'(ram_wren), 32'(vecs[i].wren));
      chk($sformatf("vec%0d_ram_address", i), 32'(ram_address), 32'(vecs[i].addr));
      chk($sformatf("vec%0d_ram_data", i), 32'(ram_data), 32'(vecs[i].data));
      chk($sformatf("vec%0d_cpu_rst", i), 32'(cpu_rst), 32'(vecs[i].crst));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].done));
    end
    @(negedge clk);
    rst = 0; start = 0; s_valid = 0; s_data = 0;
    cpu_m_address = 0; cpu_m_data = 0; cpu_memw = 0;

    // Address wrap at the top of a 19-bit space
    @(negedge clk); w_start = 1; #1;
    chk("wrap_idle_cpu_rst", 32'(w_cpu_rst), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); w_start = 0; w_valid = 1; s_data = wb[i]; #1;
      chk($sformatf("wrap%0d_s_ready", i), 32'(w_ready), 32'd1);
      if (i > 0) begin
        chk($sformatf("wrap%0d_wren", i), 32'(w_wren), 32'd1);
        chk($sformatf("wrap%0d_addr", i), 32'(w_address), 32'(wa[i-1]));
        chk($sformatf("wrap%0d_data", i), 32'(w_data), 32'(wb[i-1]));
      end
    end
    @(negedge clk); w_valid = 0; #1;
    chk("wrap_flush_wren", 32'(w_wren), 32'd1);
    chk("wrap_flush_addr", 32'(w_address), 32'(wa[3]));
    chk("wrap_flush_data", 32'(w_data), 32'(wb[3]));
    chk("wrap_flush_s_ready", 32'(w_ready), 32'd0);
    @(negedge clk); #1;
    chk("wrap_run_cpu_rst", 32'(w_cpu_rst), 32'd0);
    chk("wrap_run_done", 32'(w_done), 32'd1);

    // Single-byte load goes straight to FLUSH
    @(negedge clk); o_start = 1;
    @(negedge clk); o_start = 0; o_valid = 1; s_data = 8'h9C; #1;
    chk("one_load_s_ready", 32'(o_ready), 32'd1);
    chk("one_load_wren", 32'(o_wren), 32'd0);
    @(negedge clk); o_valid = 0; #1;
    chk("one_flush_wren", 32'(o_wren), 32'd1);
    chk("one_flush_addr", 32'(o_address), 32'h5);
    chk("one_flush_data", 32'(o_data), 32'h9C);
    chk("one_flush_busy", 32'(o_busy), 32'd1);
    chk("one_flush_s_ready", 32'(o_ready), 32'd0);
    @(negedge clk); #1;
    chk("one_run_cpu_rst", 32'(o_cpu_rst), 32'd0);
    chk("one_run_busy", 32'(o_busy), 32'd0);

    // LOAD_LEN equal to the whole address space
    @(negedge clk); f_start = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); f_start = 0; f_valid = 1; s_data = 8'(8'h30 + i); #1;
      chk($sformatf("full%0d_busy", i), 32'(f_busy), 32'd1);
      if (i > 0) begin
        chk($sformatf("full%0d_addr", i), 32'(f_address), 32'(fa[i-1]));
        chk($sformatf("full%0d_data", i), 32'(f_data), 32'(8'h30 + i - 1));
      end
    end
    @(negedge clk); f_valid = 1; s_data = 8'hFF; #1;
    chk("full_flush_addr", 32'(f_address), 32'(fa[7]));
    chk("full_flush_data", 32'(f_data), 32'h37);
    chk("full_flush_s_ready", 32'(f_ready), 32'd0);
    @(negedge clk); f_valid = 0; #1;
    chk("full_run_done", 32'(f_done), 32'd1);
    chk("full_run_wren", 32'(f_wren), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_loader.md
# data_memory_loader

Upstream loader for the RSA ASIP data memory. It fills the 8-bit data RAM with an incoming byte stream, such as an encrypted image or key material, while holding the processor in reset. Once the programmed number of bytes has been written, it releases the processor and hands the RAM port back to it. It sits between the processor's data-memory master signals and the data RAM's single write/read port.

## Interface
Parameters:
- ADDR_W, 19, RAM address width.
- BASE_ADDR, 0, first RAM address written by a load.
- LOAD_LEN, 65536, bytes per load; legal range 1..2^ADDR_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load.
- s_data  in  8  stream byte.
- s_valid  in  1  stream byte valid.
- s_ready  out  1  loader accepts byte this cycle.
- cpu_m_address  in  32  processor data address.
- cpu_m_data  in  32  processor write data.
- cpu_memw  in  1  processor write enable.
- ram_address  out  ADDR_W  to RAM address.
- ram_data  out  8  to RAM data.
- ram_wren  out  1  to RAM write enable.
- cpu_rst  out  1  processor reset, active high.
- busy  out  1  high in LOAD or FLUSH.
- done  out  1  high in RUN.

## Operation
- States: IDLE, LOAD, FLUSH, RUN. Reset enters IDLE.
- IDLE:
  - cpu_rst=1, s_ready=0, ram_wren=0, busy=0, done=0.
  - start=1 moves to LOAD and sets count=0.
- LOAD:
  - s_ready=1, cpu_rst=1, busy=1.
  - On s_valid&s_ready, latch the byte and the address (BASE_ADDR+count) mod 2^ADDR_W into a pending-write register, then increment count.
  - When the accepted byte has count==LOAD_LEN-1, move to FLUSH.
  - The pending write drives ram_address/ram_data with ram_wren=1 in the next cycle. Otherwise ram_wren=0.
- FLUSH:
  - One cycle. Issues the last pending write with ram_wren=1.
  - s_ready=0, cpu_rst=1, busy=1.
  - Always moves to RUN.
- RUN:
  - cpu_rst=0, done=1, busy=0, s_ready=0.
  - RAM port mux passes cpu_m_address[ADDR_W-1:0], cpu_m_data[7:0] and cpu_memw combinationally.
  - start=1 moves to LOAD and sets count=0. cpu_rst rises in the same cycle the state becomes LOAD. Stored RAM contents are not cleared.
- start is ignored in LOAD and FLUSH.
- s_valid is ignored when s_ready=0. No byte is consumed.
- count is ADDR_W+1 bits wide so that LOAD_LEN=2^ADDR_W is legal. Address addition wraps modulo 2^ADDR_W.
- In every state other than RUN, the processor signals never reach the RAM.
- RAM read data is not routed through this block; the processor reads q directly.

## Timing
- Reset values of all outputs: s_ready=0, ram_wren=0, ram_address=0, ram_data=0, cpu_rst=1, busy=0, done=0.
- Acceptance latency: a byte accepted at edge k is written at cycle k+1. At most one write is in flight.
- Back-to-back acceptance is allowed: sustained s_valid=1 gives one byte per cycle, with no bubbles until FLUSH.
- The last byte is accepted at cycle N, written at N+1 (FLUSH), and cpu_rst falls at N+2 (RUN). The processor never runs while a loader write is outstanding.
- Reset mid-load:
  - The next edge returns to IDLE and the pending write is dropped (ram_wren=0).
  - cpu_rst stays 1 and count clears.
  - Bytes already written remain in RAM.
- Simultaneous rst and start: rst wins.
- LOAD_LEN=1: the first accepted byte goes directly to FLUSH.

## Test plan
- Reset/idle:
  - Stimulus: assert rst 2 cycles.
  - Required: all outputs hold their reset values. s_valid=1 in IDLE gives s_ready=0 and no writes.
- Continuous load (BASE_ADDR=0x100, LOAD_LEN=4):
  - Stimulus: start pulse, then bytes A1,B2,C3,D4 on consecutive cycles.
  - Required: writes to 0x100..0x103 on consecutive cycles, FLUSH carries D4@0x103, and cpu_rst falls 2 cycles after the D4 accept.
- Backpressure/gaps:
  - Stimulus: same load with s_valid toggled 1,0,0,1,1,0,1.
  - Required: exactly 4 writes in the correct address order, and ram_wren=0 on idle cycles.
- Ignored start and mid-load reset:
  - Stimulus: a second start after 2 bytes.
  - Required: no count restart.
  - Stimulus: rst after 2 bytes.
  - Required: back to IDLE, no 3rd write, cpu_rst=1.
- Run passthrough and reload:
  - Stimulus: in RUN, cpu_m_address=0x0ABCDE, cpu_m_data=0x5A, cpu_memw=1.
  - Required: ram_address=0x2BCDE, ram_data=0x5A, ram_wren=1 in the same cycle.
  - Stimulus: a start in RUN.
  - Required: cpu_rst=1, and the next load writes from BASE_ADDR.
- Wrap-around (BASE_ADDR=0x7FFFE, LOAD_LEN=4):
  - Required: writes land at 0x7FFFE, 0x7FFFF, 0x00000, 0x00001.
